imm_encoder: RTL and testbench
==============================

IMM_ENCODER -- requirements
Module: imm_encoder

Interface
REQ-001 Parameter: CNT_W, 16, width of the emitted-instruction counter.
REQ-002 CLK  input  1  rising-edge clock; one clock domain only.
REQ-003 Reset  input  1  reset; synchronous and active-high.
REQ-004 Start  input  1  one-cycle pulse; load Addr from StartAddr, abort any in-flight request.
REQ-005 StartAddr  input  64  base instruction-memory byte address.
REQ-006 InValid  input  1  request valid.
REQ-007 InReady  output  1  encoder can accept a request.
REQ-008 Fmt  input  2  format: 0=B, 1=LDUR, 2=STUR, 3=CBZ.
REQ-009 Rt  input  5  target/test register; ignored for B.
REQ-010 Rn  input  5  base register; used by LDUR/STUR only.
REQ-011 Imm  input  64  signed immediate, already in field units.
REQ-012 OutValid  output  1  Instr32/Addr valid.
REQ-013 OutReady  input  1  consumer (instruction-memory writer) accepts.
REQ-014 Instr32  output  32  encoded instruction word.
REQ-015 Addr  output  64  byte address at which Instr32 is written.
REQ-016 Err  output  1  one-cycle pulse: immediate out of range, request dropped.
REQ-017 Count  output  CNT_W  instructions emitted since Reset/Start.

Function
REQ-018 Encodings SHALL be: B = 000101 | imm[25:0]; LDUR = 11111000010 | imm[8:0] | 00 | Rn | Rt; STUR = 11111000000 | imm[8:0] | 00 | Rn | Rt; CBZ = 10110100 | imm[18:0] | Rt.
REQ-019 Fit rule: Imm fits a W-bit field (B 26, LDUR/STUR 9, CBZ 19) iff Imm[63:W-1] are all equal.
REQ-020 FSM states: IDLE, CHECK, HOLD, ERR.
REQ-021 IDLE: InReady=1; InValid&InReady captures Fmt/Rt/Rn/Imm, goes to CHECK.
REQ-022 CHECK: InReady=0; fit -> register Instr32, go to HOLD; no fit -> ERR.
REQ-023 HOLD: OutValid=1; Instr32/Addr stable until OutValid&OutReady; on handshake Addr+=4, Count+=1, go to IDLE.
REQ-024 ERR: Err=1 for exactly one cycle; Addr/Count unchanged; go to IDLE.
REQ-025 Latency: request accepted in cycle N -> OutValid first high in cycle N+2 (or Err high in N+2).
REQ-026 Throughput: at most one request per 3 cycles; OutReady held high gives accept, check, emit cycles.
REQ-027 Start (any state): Addr<=StartAddr, Count<=0, state<=IDLE, captured request discarded, no Err; Start and InValid together -> request not accepted that cycle.
REQ-028 Addr wraps modulo 2^64; Count saturates at all-ones.
REQ-029 OutValid SHALL NOT depend combinationally on OutReady; InReady SHALL NOT depend combinationally on InValid.

Reset
REQ-030 Reset SHALL take precedence over Start and every handshake, effective at the next edge.
REQ-031 Reset values: state IDLE, InReady 1 after reset cycle, OutValid 0, Err 0, Instr32 0, Addr 0, Count 0.
REQ-032 Reset mid-operation (CHECK/HOLD/ERR) SHALL drop the request with no Err and no Addr advance.

Structure
REQ-033 Shared package SHALL hold: Fmt codes, opcode constants (000101, 1984, 1986, 10110100), field widths 26/9/19, FSM state encoding.
REQ-034 Sub-module imm_fit_check (combinational: Imm, Fmt -> fits) SHALL implement REQ-019; all else in imm_encoder.

Verification
REQ-035 LDUR Rt=1 Rn=2 Imm=-8 -> Instr32=0xF85F8041, Addr=StartAddr, OutValid at N+2.
REQ-036 STUR Rt=0 Rn=31 Imm=255 -> 0xF80FF3E0; then STUR Imm=256 -> Err pulse, no OutValid, Addr unchanged.
REQ-037 B Imm=1 -> 0x14000001; B Imm=2^25 -> Err; B Imm=-(2^25) -> 0x16000000.
REQ-038 CBZ Rt=3 Imm=-1 with OutReady low 5 cycles -> 0xB4FFFFE3 held stable 5 cycles, then Addr+=4, Count=1.
REQ-039 Start=1 in HOLD with StartAddr=0x100 -> OutValid drops next cycle, Addr=0x100, Count=0, no Err.
REQ-040 Reset asserted in CHECK -> next cycle all outputs at reset values; subsequent request encodes at Addr 0.

Source files
------------

// File: rtl/imm_encoder_pkg.sv
// imm_encoder_pkg: format codes, opcodes, field widths and FSM states shared by the encoder slice
package imm_encoder_pkg;
  typedef enum logic [1:0] {FMT_B, FMT_LDUR, FMT_STUR, FMT_CBZ} fmt_t;
  typedef enum logic [1:0] {IDLE, CHECK, HOLD, ERR} state_t;
  localparam logic [5:0] OP_B = 6'b000101;
  localparam logic [10:0] OP_STUR = 11'd1984;
  localparam logic [10:0] OP_LDUR = 11'd1986;
  localparam logic [7:0] OP_CBZ = 8'b10110100;
  localparam int W_B = 26;
  localparam int W_LS = 9;
  localparam int W_CBZ = 19;
endpackage

// File: rtl/imm_encoder_if.sv
// imm_encoder_if: request, emit and control signals of the immediate encoder
interface imm_encoder_if import imm_encoder_pkg::*; #(parameter int CNT_W = 16);
  logic Start;
  logic [63:0] StartAddr;
  logic InValid;
  logic InReady;
  fmt_t Fmt;
  logic [4:0] Rt;
  logic [4:0] Rn;
  logic [63:0] Imm;
  logic OutValid;
  logic OutReady;
  logic [31:0] Instr32;
  logic [63:0] Addr;
  logic Err;
  logic [CNT_W-1:0] Count;
  modport master(output Start, StartAddr, InValid, Fmt, Rt, Rn, Imm, OutReady,
                 input InReady, OutValid, Instr32, Addr, Err, Count);
  modport slave(input Start, StartAddr, InValid, Fmt, Rt, Rn, Imm, OutReady,
                output InReady, OutValid, Instr32, Addr, Err, Count);
endinterface

// File: rtl/imm_fit_check.sv
// imm_fit_check: true when the signed immediate fits the field width of its format
module imm_fit_check import imm_encoder_pkg::*; (
  input logic [63:0] Imm,
  input fmt_t Fmt,
  output logic Fits
);
  logic [5:0] sh;
  logic [63:0] top;
  // Bits [63:W-1] shifted down arithmetically must be all zeros or all ones
  always_comb begin
    sh = Fmt == FMT_B ? 6'(W_B - 1) : Fmt == FMT_CBZ ? 6'(W_CBZ - 1) : 6'(W_LS - 1);
    top = $signed(Imm) >>> sh;
    Fits = &top | ~|top;
  end
endmodule

// File: rtl/imm_encoder.sv
// imm_encoder: range-checks and encodes B/LDUR/STUR/CBZ immediates into sequential instruction words
module imm_encoder import imm_encoder_pkg::*; #(parameter int CNT_W = 16) (
  input logic CLK,
  input logic Reset,
  imm_encoder_if.slave bus
);
  state_t state;
  fmt_t fmtQ;
  logic [4:0] rtQ;
  logic [4:0] rnQ;
  logic [63:0] immQ;
  logic fits;
  logic [31:0] enc;
  imm_fit_check fitCheck (.Imm(immQ), .Fmt(fmtQ), .Fits(fits));
  always_comb
    enc = fmtQ == FMT_B ? {OP_B, immQ[W_B-1:0]}
        : fmtQ == FMT_CBZ ? {OP_CBZ, immQ[W_CBZ-1:0], rtQ}
        : {fmtQ == FMT_LDUR ? OP_LDUR : OP_STUR, immQ[W_LS-1:0], 2'b00, rnQ, rtQ};
  always_ff @(posedge CLK) begin
    if (Reset) begin
      state <= IDLE;
      fmtQ <= FMT_B;
      rtQ <= '0;
      rnQ <= '0;
      immQ <= '0;
      bus.InReady <= 1'b1;
      bus.OutValid <= 1'b0;
      bus.Err <= 1'b0;
      bus.Instr32 <= '0;
      bus.Addr <= '0;
      bus.Count <= '0;
    end else if (bus.Start) begin
      state <= IDLE;
      bus.InReady <= 1'b1;
      bus.OutValid <= 1'b0;
      bus.Err <= 1'b0;
      bus.Addr <= bus.StartAddr;
      bus.Count <= '0;
    end else begin
      case (state)
        IDLE: if (bus.InValid) begin
          fmtQ <= bus.Fmt;
          rtQ <= bus.Rt;
          rnQ <= bus.Rn;
          immQ <= bus.Imm;
          bus.InReady <= 1'b0;
          state <= CHECK;
        end
        CHECK: if (fits) begin
          bus.Instr32 <= enc;
          bus.OutValid <= 1'b1;
          state <= HOLD;
        end else begin
          bus.Err <= 1'b1;
          state <= ERR;
        end
        HOLD: if (bus.OutReady) begin
          bus.OutValid <= 1'b0;
          bus.Addr <= bus.Addr + 64'd4;
          bus.Count <= bus.Count + CNT_W'(~&bus.Count);
          bus.InReady <= 1'b1;
          state <= IDLE;
        end
        default: begin
          bus.Err <= 1'b0;
          bus.InReady <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_imm_encoder.sv
// tb_imm_encoder: scoreboard bench for imm_encoder covering encodings, range errors, backpressure, Start and Reset
module tb_imm_encoder;
  import imm_encoder_pkg::*;
  typedef struct {
    logic err;
    logic [31:0] instr;
    logic [63:0] addr;
  } exp_t;
  logic CLK = 1'b0;
  logic Reset = 1'b1;
  imm_encoder_if #(.CNT_W(16)) bus ();
  imm_encoder #(.CNT_W(16)) dut (.CLK(CLK), .Reset(Reset), .bus(bus.slave));
  always #5 CLK = ~CLK;
  exp_t sb[$];
  exp_t got;
  int nChecks = 0;
  int nFails = 0;
  logic [63:0] expAddr = '0;
  int expCount = 0;
  logic errPrev = 1'b0;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  always @(negedge CLK) begin
    if (!Reset && ((bus.OutValid && bus.OutReady) || bus.Err)) begin
      nChecks++;
      if (sb.size() == 0) begin
        nFails++;
        $display("FAIL unexpected_output: OutValid=%b Err=%b Instr32=%h, expected nothing", bus.OutValid, bus.Err, bus.Instr32);
      end else begin
        got = sb.pop_front();
        if (got.err ? (!bus.Err || bus.OutValid) : (bus.Err || bus.Instr32 !== got.instr || bus.Addr !== got.addr)) begin
          nFails++;
          $display("FAIL scoreboard: got Err=%b Instr32=%h Addr=%h, expected Err=%b Instr32=%h Addr=%h",
                   bus.Err, bus.Instr32, bus.Addr, got.err, got.instr, got.addr);
        end
      end
    end
    if (bus.Err) begin
      nChecks++;
      if (errPrev) begin
        nFails++;
        $display("FAIL err_width: Err high 2 cycles, expected 1");
      end
    end
    errPrev = bus.Err;
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  function automatic exp_t model(input logic [1:0] f, input logic [4:0] rt, input logic [4:0] rn, input logic [63:0] imm);
    exp_t e;
    int w;
    longint s, lim;
    w = f == 2'd0 ? 26 : f == 2'd3 ? 19 : 9;
    s = longint'(imm);
    lim = longint'(64'd1 << (w - 1));
    e.err = !(s >= -lim && s < lim);
    e.addr = expAddr;
    case (f)
      2'd0: e.instr = {6'b000101, imm[25:0]};
      2'd1: e.instr = {11'b11111000010, imm[8:0], 2'b00, rn, rt};
      2'd2: e.instr = {11'b11111000000, imm[8:0], 2'b00, rn, rt};
      default: e.instr = {8'b10110100, imm[18:0], rt};
    endcase
    return e;
  endfunction

  task automatic drive(input logic [1:0] f, input logic [4:0] rt, input logic [4:0] rn, input logic [63:0] imm, output int waited);
    waited = 0;
    while (!bus.InReady && waited < 30) begin
      step();
      waited++;
    end
    if (!bus.InReady) begin
      nChecks++;
      nFails++;
      $display("FAIL in_ready_timeout: InReady=%b after %0d cycles, expected 1", bus.InReady, waited);
    end
    bus.InValid = 1'b1;
    bus.Fmt = fmt_t'(f);
    bus.Rt = rt;
    bus.Rn = rn;
    bus.Imm = imm;
    step();
    bus.InValid = 1'b0;
  endtask

  task automatic send(input logic [1:0] f, input logic [4:0] rt, input logic [4:0] rn, input logic [63:0] imm, output int waited);
    exp_t e;
    e = model(f, rt, rn, imm);
    sb.push_back(e);
    if (!e.err) begin
      expAddr += 64'd4;
      expCount++;
    end
    drive(f, rt, rn, imm, waited);
  endtask

  task automatic wait_idle();
    int t = 0;
    while (!(bus.InReady && sb.size() == 0) && t < 40) begin
      step();
      t++;
    end
    nChecks++;
    if (!(bus.InReady && sb.size() == 0)) begin
      nFails++;
      $display("FAIL idle_timeout: InReady=%b pending=%0d, expected 1 and 0", bus.InReady, sb.size());
    end
  endtask

  task automatic do_start(input logic [63:0] a);
    bus.Start = 1'b1;
    bus.StartAddr = a;
    step();
    bus.Start = 1'b0;
    expAddr = a;
    expCount = 0;
  endtask

  task automatic test_reset();
    step();
    step();
    nChecks++;
    if (bus.InReady !== 1'b1 || bus.OutValid !== 1'b0 || bus.Err !== 1'b0 || bus.Instr32 !== 32'h0 || bus.Addr !== 64'h0 || bus.Count !== 16'h0) begin
      nFails++;
      $display("FAIL reset_values: InReady=%b OutValid=%b Err=%b Instr32=%h Addr=%h Count=%h, expected 1 0 0 0 0 0",
               bus.InReady, bus.OutValid, bus.Err, bus.Instr32, bus.Addr, bus.Count);
    end
    Reset = 1'b0;
    step();
  endtask

  task automatic test_ldur();
    int w;
    do_start(64'h1000);
    nChecks++;
    if (bus.Addr !== 64'h1000 || bus.Count !== 16'h0) begin
      nFails++;
      $display("FAIL start_load: Addr=%h Count=%0d, expected 1000 0", bus.Addr, bus.Count);
    end
    send(2'd1, 5'd1, 5'd2, -64'sd8, w);
    nChecks++;
    if (bus.OutValid !== 1'b0) begin
      nFails++;
      $display("FAIL ldur_latency_early: OutValid=%b in N+1, expected 0", bus.OutValid);
    end
    step();
    nChecks++;
    if (bus.OutValid !== 1'b1 || bus.Instr32 !== 32'hF85F8041 || bus.Addr !== 64'h1000) begin
      nFails++;
      $display("FAIL ldur_encode: OutValid=%b Instr32=%h Addr=%h, expected 1 F85F8041 1000", bus.OutValid, bus.Instr32, bus.Addr);
    end
    step();
    nChecks++;
    if (bus.Count !== 16'd1 || bus.Addr !== 64'h1004) begin
      nFails++;
      $display("FAIL ldur_advance: Count=%0d Addr=%h, expected 1 1004", bus.Count, bus.Addr);
    end
  endtask

  task automatic test_stur_range();
    int w;
    send(2'd2, 5'd0, 5'd31, 64'd255, w);
    step();
    nChecks++;
    if (bus.Instr32 !== 32'hF80FF3E0) begin
      nFails++;
      $display("FAIL stur_encode: Instr32=%h, expected F80FF3E0", bus.Instr32);
    end
    wait_idle();
    send(2'd2, 5'd0, 5'd0, 64'd256, w);
    step();
    nChecks++;
    if (bus.Err !== 1'b1 || bus.OutValid !== 1'b0) begin
      nFails++;
      $display("FAIL stur_range_err: Err=%b OutValid=%b, expected 1 0", bus.Err, bus.OutValid);
    end
    step();
    nChecks++;
    if (bus.Err !== 1'b0 || bus.Addr !== 64'h1008 || bus.Count !== 16'd2) begin
      nFails++;
      $display("FAIL stur_err_effect: Err=%b Addr=%h Count=%0d, expected 0 1008 2", bus.Err, bus.Addr, bus.Count);
    end
  endtask

  task automatic test_branch();
    int w;
    send(2'd0, 5'd7, 5'd9, 64'd1, w);
    step();
    nChecks++;
    if (bus.Instr32 !== 32'h14000001) begin
      nFails++;
      $display("FAIL b_encode: Instr32=%h, expected 14000001", bus.Instr32);
    end
    wait_idle();
    send(2'd0, 5'd0, 5'd0, 64'd1 << 25, w);
    step();
    nChecks++;
    if (bus.Err !== 1'b1) begin
      nFails++;
      $display("FAIL b_range_err: Err=%b, expected 1", bus.Err);
    end
    wait_idle();
    send(2'd0, 5'd0, 5'd0, -(64'sd1 <<< 25), w);
    step();
    nChecks++;
    if (bus.Instr32 !== 32'h16000000) begin
      nFails++;
      $display("FAIL b_neg_edge: Instr32=%h, expected 16000000", bus.Instr32);
    end
    wait_idle();
  endtask

  task automatic test_cbz_backpressure();
    int w;
    do_start(64'h2000);
    bus.OutReady = 1'b0;
    send(2'd3, 5'd3, 5'd0, -64'sd1, w);
    step();
    for (int i = 0; i < 5; i++) begin
      nChecks++;
      if (bus.OutValid !== 1'b1 || bus.Instr32 !== 32'hB4FFFFE3 || bus.Addr !== 64'h2000) begin
        nFails++;
        $display("FAIL cbz_hold[%0d]: OutValid=%b Instr32=%h Addr=%h, expected 1 B4FFFFE3 2000", i, bus.OutValid, bus.Instr32, bus.Addr);
      end
      step();
    end
    bus.OutReady = 1'b1;
    step();
    nChecks++;
    if (bus.Addr !== 64'h2004 || bus.Count !== 16'd1 || bus.OutValid !== 1'b0) begin
      nFails++;
      $display("FAIL cbz_release: Addr=%h Count=%0d OutValid=%b, expected 2004 1 0", bus.Addr, bus.Count, bus.OutValid);
    end
  endtask

  task automatic test_start_in_hold();
    int w;
    bus.OutReady = 1'b0;
    drive(2'd1, 5'd4, 5'd5, 64'd3, w);
    step();
    do_start(64'h100);
    nChecks++;
    if (bus.OutValid !== 1'b0 || bus.Addr !== 64'h100 || bus.Count !== 16'd0 || bus.Err !== 1'b0) begin
      nFails++;
      $display("FAIL start_in_hold: OutValid=%b Addr=%h Count=%0d Err=%b, expected 0 100 0 0", bus.OutValid, bus.Addr, bus.Count, bus.Err);
    end
    bus.InValid = 1'b1;
    bus.Start = 1'b1;
    step();
    bus.InValid = 1'b0;
    bus.Start = 1'b0;
    nChecks++;
    if (bus.InReady !== 1'b1) begin
      nFails++;
      $display("FAIL start_blocks_accept: InReady=%b, expected 1", bus.InReady);
    end
    step();
    step();
    nChecks++;
    if (bus.OutValid !== 1'b0 || bus.Err !== 1'b0) begin
      nFails++;
      $display("FAIL start_no_emit: OutValid=%b Err=%b, expected 0 0", bus.OutValid, bus.Err);
    end
    bus.OutReady = 1'b1;
  endtask

  task automatic test_reset_in_check();
    int w;
    drive(2'd1, 5'd1, 5'd1, 64'd1, w);
    Reset = 1'b1;
    step();
    nChecks++;
    if (bus.InReady !== 1'b1 || bus.OutValid !== 1'b0 || bus.Err !== 1'b0 || bus.Instr32 !== 32'h0 || bus.Addr !== 64'h0 || bus.Count !== 16'h0) begin
      nFails++;
      $display("FAIL reset_in_check: InReady=%b OutValid=%b Err=%b Instr32=%h Addr=%h Count=%h, expected 1 0 0 0 0 0",
               bus.InReady, bus.OutValid, bus.Err, bus.Instr32, bus.Addr, bus.Count);
    end
    Reset = 1'b0;
    expAddr = '0;
    expCount = 0;
    step();
    send(2'd2, 5'd6, 5'd7, 64'd10, w);
    wait_idle();
    nChecks++;
    if (bus.Addr !== 64'h4 || bus.Count !== 16'd1) begin
      nFails++;
      $display("FAIL after_reset_emit: Addr=%h Count=%0d, expected 4 1", bus.Addr, bus.Count);
    end
  endtask

  task automatic test_back_to_back();
    int w, k, waited;
    logic [1:0] f;
    longint lim, imm;
    for (int i = 0; i < 16; i++) begin
      f = 2'($urandom_range(0, 3));
      w = f == 2'd0 ? 26 : f == 2'd3 ? 19 : 9;
      lim = longint'(64'd1 << (w - 1));
      k = $urandom_range(0, 5);
      imm = k == 0 ? 0 : k == 1 ? lim - 1 : k == 2 ? lim : k == 3 ? -lim : k == 4 ? -lim - 1 : longint'($signed(32'($urandom)));
      send(f, 5'($urandom), 5'($urandom), 64'(imm), waited);
      if (i > 0) begin
        nChecks++;
        if (waited != 2) begin
          nFails++;
          $display("FAIL throughput[%0d]: waited %0d cycles for InReady, expected 2", i, waited);
        end
      end
    end
    wait_idle();
    nChecks++;
    if (bus.Count !== 16'(expCount) || bus.Addr !== expAddr) begin
      nFails++;
      $display("FAIL b2b_totals: Count=%0d Addr=%h, expected %0d %h", bus.Count, bus.Addr, expCount, expAddr);
    end
  endtask

  initial begin
    bus.Start = 1'b0;
    bus.StartAddr = '0;
    bus.InValid = 1'b0;
    bus.Fmt = FMT_B;
    bus.Rt = '0;
    bus.Rn = '0;
    bus.Imm = '0;
    bus.OutReady = 1'b1;
    test_reset();
    test_ldur();
    test_stur_range();
    test_branch();
    test_cbz_backpressure();
    test_start_in_hold();
    test_reset_in_check();
    test_back_to_back();
    step();
    nChecks++;
    if (sb.size() != 0) begin
      nFails++;
      $display("FAIL scoreboard_drain: %0d pending, expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end
endmodule
